// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: shared types and constants for the timer scheduler slice.
//   state_t   : scheduler FSM states (IDLE, RUN, DONE)
//   DEF_NREQ  : default number of requesters
//   DEF_WIDTH : default counter / terminal-count width
//   ow_width  : width of an owner index for n requesters (at least 1 bit)
package timer_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned DEF_NREQ  = 4;
   localparam int unsigned DEF_WIDTH = 8;

   function automatic int unsigned ow_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Ports:
//   req   in  NREQ  request bits
//   ptr   in  OW    highest-priority position; search runs upward with wrap
//   valid out 1     some request is pending
//   gnt   out NREQ  one-hot winner (0 when no request)
//   idx   out OW    winner index (0 when no request)
module rr_arbiter
   import timer_sched_pkg::*;
#(
   parameter  int unsigned NREQ = DEF_NREQ,
   localparam int unsigned OW   = ow_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [OW-1:0]   ptr,
   output logic            valid,
   output logic [NREQ-1:0] gnt,
   output logic [OW-1:0]   idx
);

   int unsigned w_pos;

   always_comb begin
      valid = 1'b0;
      gnt   = '0;
      idx   = '0;
      w_pos = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         w_pos = (32'(ptr) + k) % NREQ;
         if (!valid && req[w_pos]) begin
            valid = 1'b1;
            idx   = OW'(w_pos);
         end
      end
      if (valid) gnt[idx] = 1'b1;
   end

endmodule

// File: rtl/timer_sched.sv
// timer_sched: round-robin scheduler sharing one interval counter between
// NREQ requesters. The owner's terminal count is latched at grant; the
// counter runs 0..tc_l, then done pulses to the owner for one cycle.
// Ports:
//   clk   in  1           system clock (posedge)
//   rst   in  1           asynchronous active-high reset
//   req   in  NREQ        request level per requester
//   tc    in  NREQ*WIDTH  packed terminal counts, requester i at [i*WIDTH +: WIDTH]
//   abort in  1           cancel current run without done
//   grant out NREQ        one-hot owner, 0 when idle
//   owner out OW          index of current/last owner
//   busy  out 1           high in RUN and DONE
//   count out WIDTH       current counter value
//   done  out NREQ        one-cycle end-of-run pulse to the owner
module timer_sched
   import timer_sched_pkg::*;
#(
   parameter  int unsigned NREQ  = DEF_NREQ,
   parameter  int unsigned WIDTH = DEF_WIDTH,
   localparam int unsigned OW    = ow_width(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] tc,
   input  logic                  abort,
   output logic [NREQ-1:0]       grant,
   output logic [OW-1:0]         owner,
   output logic                  busy,
   output logic [WIDTH-1:0]      count,
   output logic [NREQ-1:0]       done
);

   state_t            r_state, w_state_nx;
   logic [NREQ-1:0]   r_grant, w_grant_nx;
   logic [OW-1:0]     r_owner, w_owner_nx;
   logic [WIDTH-1:0]  r_count, w_count_nx;
   logic [NREQ-1:0]   r_done,  w_done_nx;
   logic [OW-1:0]     r_ptr,   w_ptr_nx;
   logic [WIDTH-1:0]  r_tc_l,  w_tc_nx;
   logic              r_busy;

   logic              w_valid;
   logic [NREQ-1:0]   w_gnt;
   logic [OW-1:0]     w_idx;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req   (req),
      .ptr   (r_ptr),
      .valid (w_valid),
      .gnt   (w_gnt),
      .idx   (w_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_grant_nx = r_grant;
      w_owner_nx = r_owner;
      w_count_nx = r_count;
      w_done_nx  = '0;
      w_ptr_nx   = r_ptr;
      w_tc_nx    = r_tc_l;
      unique case (r_state)
         IDLE: begin
            w_grant_nx = '0;
            w_count_nx = '0;
            if (w_valid) begin
               w_state_nx = RUN;
               w_grant_nx = w_gnt;
               w_owner_nx = w_idx;
               w_tc_nx    = tc[32'(w_idx)*WIDTH +: WIDTH];
               w_ptr_nx   = (32'(w_idx) == NREQ-1) ? '0 : w_idx + OW'(1);
            end
         end
         RUN: begin
            // Cancellation outranks the terminal-count compare.
            if (abort || !req[r_owner]) begin
               w_state_nx = IDLE;
               w_grant_nx = '0;
               w_count_nx = '0;
            end else if (r_count == r_tc_l) begin
               w_state_nx = DONE;
               w_done_nx  = r_grant;
               w_count_nx = '0;
            end else begin
               w_count_nx = r_count + WIDTH'(1);
            end
         end
         DONE: begin
            w_state_nx = IDLE;
            w_grant_nx = '0;
            w_count_nx = '0;
         end
         default: begin
            w_state_nx = IDLE;
            w_grant_nx = '0;
            w_count_nx = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant <= '0;
         r_owner <= '0;
         r_count <= '0;
         r_done  <= '0;
         r_ptr   <= '0;
         r_tc_l  <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_grant <= w_grant_nx;
         r_owner <= w_owner_nx;
         r_count <= w_count_nx;
         r_done  <= w_done_nx;
         r_ptr   <= w_ptr_nx;
         r_tc_l  <= w_tc_nx;
         r_busy  <= (w_state_nx != IDLE);
      end
   end

   assign grant = r_grant;
   assign owner = r_owner;
   assign busy  = r_busy;
   assign count = r_count;
   assign done  = r_done;

endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched (NREQ=4, WIDTH=8): a constant vector table, a few
// hand-written multi-cycle sequences, and a randomized run against a
// transaction-level reference model.
module tb_timer_sched;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] tc;
   logic        abort;
   logic [3:0]  grant;
   logic [1:0]  owner;
   logic        busy;
   logic [7:0]  count;
   logic [3:0]  done;

   always #5 clk = ~clk;

   timer_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .tc    (tc),
      .abort (abort),
      .grant (grant),
      .owner (owner),
      .busy  (busy),
      .count (count),
      .done  (done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // {grant, owner, busy, count, done}
   function automatic logic [18:0] obs();
      return {grant, owner, busy, count, done};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      req   = '0;
      tc    = '0;
      abort = 1'b0;
      rst   = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- reference model (transaction view) ----------------
   int m_own;      // current owner, -1 when idle
   int m_elapsed;  // cycles counted in the current run
   int m_lim;      // terminal count latched at grant
   int m_ptr;
   int m_last;
   bit m_indone;

   function automatic void m_reset();
      m_own = -1; m_elapsed = 0; m_lim = 0; m_ptr = 0; m_last = 0; m_indone = 1'b0;
   endfunction

   function automatic void m_step(input logic [3:0] r, input logic [31:0] t, input logic a);
      if (m_indone) begin
         m_indone = 1'b0;
         m_own    = -1;
      end else if (m_own < 0) begin
         for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (r[i]) begin
               m_own     = i;
               m_last    = i;
               m_lim     = int'(t[i*WIDTH +: WIDTH]);
               m_elapsed = 0;
               m_ptr     = (i + 1) % NREQ;
               break;
            end
         end
      end else if (a || !r[m_own]) begin
         m_own = -1;
      end else if (m_elapsed == m_lim) begin
         m_indone = 1'b1;
      end else begin
         m_elapsed++;
      end
   endfunction

   function automatic logic [18:0] m_exp();
      logic [3:0] g;
      logic [7:0] c;
      logic [3:0] d;
      logic       b;
      g = '0; c = '0; d = '0; b = 1'b0;
      if (m_own >= 0) begin
         g = 4'(1 << m_own);
         b = 1'b1;
         if (m_indone) d = g;
         else          c = 8'(m_elapsed);
      end
      return {g, 2'(m_last), b, c, d};
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0]  req;
      logic [31:0] tc;
      logic        abort;
      logic [3:0]  grant;
      logic [1:0]  owner;
      logic        busy;
      logic [7:0]  count;
      logic [3:0]  done;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic [3:0] r, input logic [31:0] t, input logic a,
                               input logic [3:0] g, input logic [1:0] o, input logic b,
                               input logic [7:0] c, input logic [3:0] d);
      tbl.push_back('{r, t, a, g, o, b, c, d});
   endfunction

   localparam logic [31:0] T2_5 = 32'h0005_0000;
   localparam logic [31:0] T3_6 = 32'h0600_0000;

   initial begin
      int seq[$];
      int done_cnt[4];
      int e, done_edge, bad, maxc;
      logic [3:0] prev_g;

      // single request tc=5, then tc=0, then abort / drop / fresh request
      add(4'b0100, T2_5, 0, 4'b0100, 2, 1, 0, 4'b0000);
      for (int k = 1; k <= 5; k++) add(4'b0100, T2_5, 0, 4'b0100, 2, 1, 8'(k), 4'b0000);
      add(4'b0100, T2_5, 0, 4'b0100, 2, 1, 0, 4'b0100);
      add(4'b0000, T2_5, 0, 4'b0000, 2, 0, 0, 4'b0000);
      add(4'b0001, 32'h0, 0, 4'b0001, 0, 1, 0, 4'b0000);
      add(4'b0001, 32'h0, 0, 4'b0001, 0, 1, 0, 4'b0001);
      add(4'b0000, 32'h0, 0, 4'b0000, 0, 0, 0, 4'b0000);
      add(4'b1000, T3_6, 0, 4'b1000, 3, 1, 0, 4'b0000);
      for (int k = 1; k <= 3; k++) add(4'b1000, T3_6, 0, 4'b1000, 3, 1, 8'(k), 4'b0000);
      add(4'b1000, T3_6, 1, 4'b0000, 3, 0, 0, 4'b0000);
      add(4'b1000, T3_6, 0, 4'b1000, 3, 1, 0, 4'b0000);
      for (int k = 1; k <= 3; k++) add(4'b1000, T3_6, 0, 4'b1000, 3, 1, 8'(k), 4'b0000);
      add(4'b0000, T3_6, 0, 4'b0000, 3, 0, 0, 4'b0000);
      add(4'b0010, T3_6, 0, 4'b0010, 1, 1, 0, 4'b0000);
      add(4'b0000, T3_6, 0, 4'b0000, 1, 0, 0, 4'b0000);

      do_reset();
      chk("reset_state", 32'(obs()), 32'h0);
      for (int i = 0; i < tbl.size(); i++) begin
         req = tbl[i].req; tc = tbl[i].tc; abort = tbl[i].abort;
         tick();
         chk($sformatf("vec%0d", i), 32'(obs()),
             32'({tbl[i].grant, tbl[i].owner, tbl[i].busy, tbl[i].count, tbl[i].done}));
      end
      abort = 1'b0;

      // contention and fairness: all requesting, all tc=1
      do_reset();
      req = 4'b1111; tc = 32'h0101_0101;
      prev_g = '0;
      for (int k = 0; k < 4; k++) done_cnt[k] = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("onehot", 32'($onehot0(grant)), 32'd1);
         if (grant != 0 && prev_g == 0) begin
            for (int b = 0; b < 4; b++) if (grant[b]) seq.push_back(b);
         end
         for (int b = 0; b < 4; b++) if (done[b]) done_cnt[b]++;
         prev_g = grant;
      end
      chk("rr_nruns", 32'(seq.size()), 32'd5);
      for (int k = 0; k < 5 && k < seq.size(); k++)
         chk($sformatf("rr_order%0d", k), 32'(seq[k]), 32'(k % 4));
      for (int b = 0; b < 4; b++)
         chk($sformatf("rr_done%0d", b), 32'(done_cnt[b]), (b == 0) ? 32'd2 : 32'd1);

      // tc = 8'hFF: full-range run, no wrap, done at edge 257
      do_reset();
      req = 4'b0001; tc = 32'h0000_00FF;
      done_edge = -1; bad = 0; maxc = 0;
      for (e = 1; e <= 300 && done_edge < 0; e++) begin
         tick();
         if (done[0]) done_edge = e;
         else if (int'(count) != e - 1) bad++;
         if (int'(count) > maxc) maxc = int'(count);
      end
      chk("ff_countseq", 32'(bad), 32'd0);
      chk("ff_maxcount", 32'(maxc), 32'hFF);
      chk("ff_done_edge", 32'(done_edge), 32'd257);
      req = '0;
      tick();

      // reset mid-run is asynchronous and discards the run
      do_reset();
      req = 4'b0100; tc = 32'h0009_0000;
      for (int k = 0; k < 20 && count != 8'd4; k++) tick();
      chk("rst_reach4", 32'(count), 32'd4);
      #1 rst = 1'b1;
      #1 chk("rst_async", 32'(obs()), 32'h0);
      #1 rst = 1'b0;
      req = 4'b1010;
      tick();
      chk("rst_regrant", 32'({grant, owner}), 32'({4'b0010, 2'd1}));
      req = '0;
      tick();

      // tc changes during RUN ignored; abort during DONE ignored
      do_reset();
      req = 4'b0001; tc = 32'h0000_0003;
      tick();
      chk("tcchg_grant", 32'(grant), 32'h1);
      tc = 32'h0000_0001;
      tick();
      chk("tcchg_c1", 32'(count), 32'd1);
      tc = 32'h0000_0007;
      tick();
      chk("tcchg_c2", 32'(count), 32'd2);
      tick();
      chk("tcchg_c3", 32'(count), 32'd3);
      tick();
      chk("tcchg_done", 32'({grant, done, count}), 32'({4'b0001, 4'b0001, 8'd0}));
      abort = 1'b1;
      req   = '0;
      tick();
      chk("done_exit", 32'(obs()), 32'h0);
      abort = 1'b0;

      // randomized run against the reference model
      do_reset();
      m_reset();
      for (int k = 0; k < 3000; k++) begin
         req   = req ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
         tc    = $urandom & 32'h0707_0707;
         if ($urandom_range(0, 9) == 0) tc[7:0] = 8'($urandom_range(8, 20));
         abort = ($urandom_range(0, 19) == 0);
         @(posedge clk);
         m_step(req, tc, abort);
         @(negedge clk);
         chk($sformatf("rand%0d", k), 32'(obs()), 32'(m_exp()));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
